sb_mem_slave: RTL and testbench

// On-chip word RAM acting as a slave on the shared system bus, downstream of the JTAG debug master (jtag_if) and busArbiter.

---
 rtl/sb_mem_slave.sv | 157 +++++++++++++++
 tb/tb_sb_mem_slave.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_mem_slave.sv
// Word RAM slave on the shared system bus: single/burst reads and byte-enabled writes, range errors.
// Reads: first word READ_LATENCY cycles after begin, then 1 word/cycle; never stalls (busy tied low).
module sb_mem_slave #(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int          ADDR_WIDTH   = 10,
   parameter int          READ_LATENCY = 2
) (
   input  logic        sb_clock_i,
   input  logic        sb_reset_i,
   input  logic        sb_begin_transaction_i,
   input  logic [31:0] sb_address_data_i,
   input  logic [3:0]  sb_byte_enables_i,
   input  logic [7:0]  sb_burst_size_i,
   input  logic        sb_read_n_write_i,
   input  logic        sb_data_valid_i,
   input  logic        sb_end_transaction_i,
   input  logic        sb_error_i,
   output logic [31:0] sb_address_data_o,
   output logic        sb_data_valid_o,
   output logic        sb_end_transaction_o,
   output logic        sb_error_o,
   output logic        sb_busy_o
);

   localparam int AW    = ADDR_WIDTH;
   localparam int DEPTH = 2**AW;

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] RD_WAIT  = 3'd1;
   localparam logic [2:0] RD_BURST = 3'd2;
   localparam logic [2:0] RD_END   = 3'd3;
   localparam logic [2:0] WR       = 3'd4;
   localparam logic [2:0] ERR      = 3'd5;

   logic [2:0]    state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [7:0]    beats_q, beats_d;
   logic [8:0]    wrem_q, wrem_d;
   logic [7:0]    lat_q, lat_d;

   logic [31:0]   mem [DEPTH];
   logic [31:0]   rdata_q;
   logic [AW-1:0] rd_idx;
   logic          wr_en;

   logic          hit;
   logic [AW-1:0] req_idx;
   logic          range_err;

   assign hit       = sb_begin_transaction_i &&
                      (sb_address_data_i[31:AW+2] == BASE_ADDR[31:AW+2]);
   assign req_idx   = sb_address_data_i[AW+1:2];
   assign range_err = (32'(req_idx) + 32'(sb_burst_size_i)) > 32'(DEPTH - 1);

   // idx_q always names the next word to be fetched; rd_idx feeds the synchronous RAM read
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      beats_d = beats_q;
      wrem_d  = wrem_q;
      lat_d   = lat_q;
      rd_idx  = idx_q;
      wr_en   = 1'b0;
      case (state_q)
         IDLE: begin
            rd_idx = req_idx;
            if (hit) begin
               if (range_err) begin
                  state_d = ERR;
               end else if (sb_read_n_write_i) begin
                  beats_d = sb_burst_size_i;
                  if (READ_LATENCY == 1) begin
                     state_d = RD_BURST;
                     idx_d   = req_idx + 1'b1;
                  end else begin
                     state_d = RD_WAIT;
                     idx_d   = req_idx;
                     lat_d   = 8'(READ_LATENCY - 1);
                  end
               end else begin
                  state_d = WR;
                  idx_d   = req_idx;
                  wrem_d  = {1'b0, sb_burst_size_i} + 9'd1;
               end
            end
         end
         RD_WAIT: begin
            if (sb_error_i || sb_end_transaction_i) begin
               state_d = IDLE;
            end else begin
               lat_d = lat_q - 8'd1;
               if (lat_q == 8'd1) begin
                  state_d = RD_BURST;
                  idx_d   = idx_q + 1'b1;
               end
            end
         end
         RD_BURST: begin
            if (sb_error_i || sb_end_transaction_i) begin
               state_d = IDLE;
            end else begin
               idx_d = idx_q + 1'b1;
               if (beats_q == 8'd0) state_d = RD_END;
               else                 beats_d = beats_q - 8'd1;
            end
         end
         WR: begin
            if (sb_error_i) begin
               state_d = IDLE;
            end else begin
               if (sb_data_valid_i && (wrem_q != 9'd0)) begin
                  wr_en  = 1'b1;
                  idx_d  = idx_q + 1'b1;
                  wrem_d = wrem_q - 9'd1;
               end
               if (sb_end_transaction_i) state_d = IDLE;
            end
         end
         RD_END:  state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sb_clock_i or posedge sb_reset_i) begin
      if (sb_reset_i) begin
         state_q <= IDLE;
         idx_q   <= '0;
         beats_q <= '0;
         wrem_q  <= '0;
         lat_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         beats_q <= beats_d;
         wrem_q  <= wrem_d;
         lat_q   <= lat_d;
      end
   end

   // RAM contents survive reset
   always_ff @(posedge sb_clock_i) begin
      rdata_q <= mem[rd_idx];
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (sb_byte_enables_i[b]) mem[idx_q][8*b +: 8] <= sb_address_data_i[8*b +: 8];
         end
      end
   end

   assign sb_data_valid_o      = (state_q == RD_BURST);
   assign sb_address_data_o    = sb_data_valid_o ? rdata_q : 32'd0;
   assign sb_end_transaction_o = (state_q == RD_END);
   assign sb_error_o           = (state_q == ERR);
   assign sb_busy_o            = 1'b0;

endmodule

// File: tb/tb_sb_mem_slave.sv
// Bench for sb_mem_slave: directed and random bus transactions against an array memory model,
// expected bus responses queued with their due cycle and checked by an independent monitor.
module tb_sb_mem_slave;

   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam int          AW    = 10;
   localparam int          RL    = 2;
   localparam int          DEPTH = 1024;

   localparam logic [2:0] K_DATA = 3'b001;
   localparam logic [2:0] K_END  = 3'b010;
   localparam logic [2:0] K_ERR  = 3'b100;

   logic        clk = 1'b0;
   logic        rst;
   logic        begin_i, rnw_i, dv_i, end_i, err_i;
   logic [31:0] ad_i;
   logic [3:0]  be_i;
   logic [7:0]  bs_i;
   logic [31:0] ado;
   logic        dvo, endo, erro, busyo;

   sb_mem_slave #(.BASE_ADDR(BASE), .ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
      .sb_clock_i            (clk),
      .sb_reset_i            (rst),
      .sb_begin_transaction_i(begin_i),
      .sb_address_data_i     (ad_i),
      .sb_byte_enables_i     (be_i),
      .sb_burst_size_i       (bs_i),
      .sb_read_n_write_i     (rnw_i),
      .sb_data_valid_i       (dv_i),
      .sb_end_transaction_i  (end_i),
      .sb_error_i            (err_i),
      .sb_address_data_o     (ado),
      .sb_data_valid_o       (dvo),
      .sb_end_transaction_o  (endo),
      .sb_error_o            (erro),
      .sb_busy_o             (busyo)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [2:0]  kind;
      logic [31:0] dat;
   } exp_t;

   exp_t        sbq[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] mdl [DEPTH];
   logic [31:0] wbuf [300];
   logic [3:0]  bebuf [300];

   function automatic void push(input int c, input logic [2:0] k, input logic [31:0] d);
      exp_t e;
      e.cyc  = c;
      e.kind = k;
      e.dat  = d;
      sbq.push_back(e);
   endfunction

   function automatic bit is_hit(input logic [31:0] a);
      return (a >> (AW + 2)) == (BASE >> (AW + 2));
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [31:0] addr, input int bs, input int n, input bit gaps);
      int idx;
      idx     = int'(addr[AW+1:2]);
      begin_i = 1'b1; ad_i = addr; bs_i = 8'(bs); rnw_i = 1'b0;
      if (is_hit(addr) && (idx + bs > DEPTH - 1)) push(cyc + 1, K_ERR, 32'd0);
      tick;
      begin_i = 1'b0; ad_i = 32'd0;
      if (!is_hit(addr)) return;
      if (idx + bs > DEPTH - 1) begin
         tick;
         return;
      end
      for (int k = 0; k < n; k++) begin
         if (gaps) repeat ($urandom_range(0, 2)) tick;
         dv_i = 1'b1; ad_i = wbuf[k]; be_i = bebuf[k]; end_i = (k == n - 1);
         if (k <= bs) begin
            for (int b = 0; b < 4; b++)
               if (bebuf[k][b]) mdl[idx + k][8*b +: 8] = wbuf[k][8*b +: 8];
         end
         tick;
         dv_i = 1'b0; end_i = 1'b0; ad_i = 32'd0; be_i = 4'd0;
      end
   endtask

   task automatic do_read(input logic [31:0] addr, input int bs);
      int idx;
      int c;
      idx     = int'(addr[AW+1:2]);
      c       = cyc;
      begin_i = 1'b1; ad_i = addr; bs_i = 8'(bs); rnw_i = 1'b1;
      if (!is_hit(addr)) begin
         tick;
         begin_i = 1'b0; ad_i = 32'd0;
         return;
      end
      if (idx + bs > DEPTH - 1) begin
         push(c + 1, K_ERR, 32'd0);
         tick;
         begin_i = 1'b0; ad_i = 32'd0;
         tick;
         return;
      end
      for (int i = 0; i <= bs; i++) push(c + RL + i, K_DATA, mdl[idx + i]);
      push(c + RL + bs + 1, K_END, 32'd0);
      tick;
      begin_i = 1'b0; ad_i = 32'd0;
      repeat (RL + bs + 1) tick;
   endtask

   // Monitor: every presented output must match the head of the scoreboard, in its due cycle
   always @(negedge clk) begin
      logic [2:0] obs;
      exp_t       e;
      obs = {erro, endo, dvo};
      if (obs != 3'b000) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output cyc=%0d actual kind=%b data=%h required none", cyc, obs, ado);
         end else begin
            e = sbq.pop_front();
            if (obs !== e.kind || cyc != e.cyc || (e.kind == K_DATA && ado !== e.dat)) begin
               errors++;
               $display("FAIL bus_response actual cyc=%0d kind=%b data=%h required cyc=%0d kind=%b data=%h",
                        cyc, obs, ado, e.cyc, e.kind, (e.kind == K_DATA) ? e.dat : 32'd0);
            end
         end
      end else if (sbq.size() != 0 && sbq[0].cyc < cyc) begin
         e = sbq.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_response cyc=%0d actual none required cyc=%0d kind=%b data=%h",
                  cyc, e.cyc, e.kind, e.dat);
      end
      checks++;
      if ((!dvo && ado !== 32'd0) || busyo !== 1'b0) begin
         errors++;
         $display("FAIL bus_idle_zero cyc=%0d actual data=%h busy=%b required 0", cyc, ado, busyo);
      end
   end

   initial begin
      int          idx;
      int          bs;
      int          n;
      int          c;
      logic [31:0] addr;

      rst = 1'b1; begin_i = 1'b0; rnw_i = 1'b0; dv_i = 1'b0; end_i = 1'b0; err_i = 1'b0;
      ad_i = 32'd0; be_i = 4'd0; bs_i = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({ado, dvo, endo, erro, busyo} !== 36'd0) begin
         errors++;
         $display("FAIL reset_outputs actual=%h required 0", {ado, dvo, endo, erro, busyo});
      end
      rst = 1'b0;
      tick;

      // single word write then read
      wbuf[0] = 32'hDEAD_BEEF; bebuf[0] = 4'hF;
      do_write(32'h0000_1000, 0, 1, 1'b0);
      do_read(32'h0000_1000, 0);

      // 4-word burst
      for (int i = 0; i < 4; i++) begin wbuf[i] = i; bebuf[i] = 4'hF; end
      do_write(32'h0000_1010, 3, 4, 1'b0);
      do_read(32'h0000_1010, 3);

      // byte enables: 0xFFFFFFFF then 0x12345678 on lanes 0 and 2 reads 0xFF34FF78
      wbuf[0] = 32'hFFFF_FFFF; bebuf[0] = 4'hF;
      do_write(32'h0000_1020, 0, 1, 1'b0);
      wbuf[0] = 32'h1234_5678; bebuf[0] = 4'b0101;
      do_write(32'h0000_1020, 0, 1, 1'b0);
      do_read(32'h0000_1020, 0);

      // range error at the last word
      do_read(32'h0000_1FFC, 1);

      // miss: nothing driven for 10 cycles
      do_read(32'h9000_0000, 0);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if ({ado, dvo, endo, erro} !== 35'd0) begin
            errors++;
            $display("FAIL miss_quiet cyc=%0d actual=%h required 0", cyc, {ado, dvo, endo, erro});
         end
         tick;
      end

      // error on 2nd word of a 4-word read
      for (int i = 0; i < 4; i++) begin wbuf[i] = $urandom; bebuf[i] = 4'hF; end
      do_write(32'h0000_1100, 3, 4, 1'b0);
      c = cyc;
      begin_i = 1'b1; ad_i = 32'h0000_1100; bs_i = 8'd3; rnw_i = 1'b1;
      push(c + RL, K_DATA, mdl[64]);
      push(c + RL + 1, K_DATA, mdl[65]);
      tick; begin_i = 1'b0; ad_i = 32'd0;
      tick;
      tick; err_i = 1'b1;
      tick; err_i = 1'b0;
      repeat (6) tick;

      // end_transaction while waiting for the first read word aborts silently
      begin_i = 1'b1; ad_i = 32'h0000_1100; bs_i = 8'd3; rnw_i = 1'b1;
      tick; begin_i = 1'b0; ad_i = 32'd0; end_i = 1'b1;
      tick; end_i = 1'b0;
      repeat (6) tick;

      // reset in the middle of a burst clears outputs at once
      c = cyc;
      begin_i = 1'b1; ad_i = 32'h0000_1100; bs_i = 8'd3; rnw_i = 1'b1;
      push(c + RL, K_DATA, mdl[64]);
      tick; begin_i = 1'b0; ad_i = 32'd0;
      tick;
      tick; rst = 1'b1;
      #1;
      checks++;
      if ({ado, dvo, endo, erro} !== 35'd0) begin
         errors++;
         $display("FAIL reset_mid_burst actual=%h required 0", {ado, dvo, endo, erro});
      end
      tick; rst = 1'b0;
      tick;
      do_read(32'h0000_1100, 3);

      // fill the whole RAM so random reads have known contents
      for (int blk = 0; blk < 4; blk++) begin
         for (int i = 0; i < 256; i++) begin wbuf[i] = $urandom; bebuf[i] = 4'hF; end
         do_write(BASE + 32'(blk * 1024), 255, 256, 1'b0);
      end

      for (int t = 0; t < 80; t++) begin
         idx  = $urandom_range(0, DEPTH - 1);
         addr = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 99) < 4) addr = addr ^ 32'h8000_0000;
         if ($urandom_range(0, 9) == 0) bs = $urandom_range(0, 255);
         else                           bs = $urandom_range(0, 7);
         if ($urandom_range(0, 1) == 1) begin
            do_read(addr, bs);
         end else begin
            case ($urandom_range(0, 3))
               0:       n = $urandom_range(1, bs + 1);
               1:       n = bs + 2;
               default: n = bs + 1;
            endcase
            for (int i = 0; i < n; i++) begin wbuf[i] = $urandom; bebuf[i] = 4'($urandom); end
            do_write(addr, bs, n, 1'b1);
         end
      end

      repeat (10) tick;
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drained actual=%0d pending required 0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
